usb_in_packetizer: RTL and testbench



---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_pkt_buf.sv | 39 +++
 rtl/usb_in_packetizer.sv | 206 ++++++++++++++++++++
 tb/tb_usb_in_packetizer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the USB IN-endpoint packetizer: handshake codes,
// packetizer state encoding, default packet size and a width helper.
package usb_pkg;

    localparam logic [1:0] HS_ACK   = 2'b00;
    localparam logic [1:0] HS_NONE  = 2'b01;
    localparam logic [1:0] HS_NAK   = 2'b10;
    localparam logic [1:0] HS_STALL = 2'b11;

    localparam int unsigned MAX_PKT_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_FILL     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_SEND     = 2'd2,
        ST_WAIT_END = 2'd3
    } pkt_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/usb_pkt_buf.sv
// Packet buffer: DEPTH x 8 simple dual-port RAM, synchronous write and
// registered read whose output register is cleared on reset.
module usb_pkt_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (clr_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/usb_in_packetizer.sv
// IN-endpoint packetizer: packs a byte stream into IN packets, answers IN
// tokens for one endpoint and replays unacknowledged packets unchanged.
module usb_in_packetizer
    import usb_pkg::*;
#(
    parameter int unsigned EP_NUM       = 1,
    parameter int unsigned MAX_PKT      = MAX_PKT_DEFAULT,
    parameter int unsigned IDLE_TIMEOUT = 4800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_rst,
    input  logic       transaction_active,
    input  logic [3:0] endpoint,
    input  logic       direction_in,
    input  logic       setup,
    input  logic       success,
    input  logic       data_strobe,
    output logic [7:0] data_in,
    output logic       data_in_valid,
    output logic       data_toggle,
    output logic [1:0] handshake,
    output logic       ep_sel,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    input  logic       flush,
    input  logic       stall,
    input  logic       clear_toggle
);

    localparam int unsigned AW = clog2(MAX_PKT);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned IW = clog2(IDLE_TIMEOUT + 1);
    localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_PKT);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

    pkt_state_e    state_q, state_d;
    logic [LW-1:0] pkt_len_q, pkt_len_d;
    logic [LW-1:0] rd_idx_q, rd_idx_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          ta_q, seen_q, seen_d;
    logic          ep_sel_q, ep_sel_d;
    logic [1:0]    hs_q, hs_d;
    logic          valid_q, valid_d;
    logic          toggle_q, toggle_d;
    logic          src_ready_q, src_ready_d;

    logic          accept, tx_start, buf_wr_en, buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [LW-1:0] next_idx;
    logic [7:0]    buf_rd_data;

    assign accept   = src_valid & src_ready_q;
    assign tx_start = transaction_active & ~ta_q & (endpoint == 4'(EP_NUM))
                    & direction_in & ~setup;
    assign next_idx = rd_idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        pkt_len_d   = pkt_len_q;
        rd_idx_d    = rd_idx_q;
        idle_cnt_d  = idle_cnt_q;
        seen_d      = seen_q;
        ep_sel_d    = ep_sel_q;
        hs_d        = hs_q;
        valid_d     = valid_q;
        toggle_d    = toggle_q;
        buf_wr_en   = 1'b0;
        buf_rd_en   = 1'b0;
        buf_rd_addr = rd_idx_q[AW-1:0];

        if (state_q == ST_FILL) begin
            if (accept) begin
                buf_wr_en  = 1'b1;
                pkt_len_d  = pkt_len_q + 1'b1;
                idle_cnt_d = '0;
            end else if (idle_cnt_q != IDLE_MAX) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (pkt_len_d == MAX_LEN || flush ||
                (pkt_len_q != '0 && idle_cnt_q == IDLE_MAX)) begin
                state_d = ST_ARMED;
            end
        end

        if (tx_start) begin
            ep_sel_d = 1'b1;
            seen_d   = success;
            if (stall) begin
                hs_d = HS_STALL;
            end else if (state_q == ST_ARMED) begin
                hs_d        = HS_ACK;
                state_d     = ST_SEND;
                rd_idx_d    = '0;
                buf_rd_en   = 1'b1;
                buf_rd_addr = '0;
                valid_d     = (pkt_len_q != '0);
            end else begin
                hs_d = HS_NAK;
            end
        end else if (ep_sel_q) begin
            if (transaction_active) begin
                if (success) begin
                    seen_d = 1'b1;
                end
                if (state_q == ST_SEND) begin
                    if (!valid_q) begin
                        state_d = ST_WAIT_END;
                    end else if (data_strobe) begin
                        // Prefetch the following byte so it is on data_in one cycle later.
                        rd_idx_d    = next_idx;
                        buf_rd_en   = (next_idx != pkt_len_q);
                        buf_rd_addr = next_idx[AW-1:0];
                        valid_d     = (next_idx != pkt_len_q);
                        if (next_idx == pkt_len_q) begin
                            state_d = ST_WAIT_END;
                        end
                    end
                end
            end else begin
                ep_sel_d = 1'b0;
                hs_d     = HS_NONE;
                valid_d  = 1'b0;
                if (state_q == ST_SEND || state_q == ST_WAIT_END) begin
                    if (seen_q) begin
                        toggle_d   = ~toggle_q;
                        pkt_len_d  = '0;
                        idle_cnt_d = '0;
                        state_d    = ST_FILL;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
            end
        end

        if (clear_toggle) begin
            toggle_d = 1'b0;
        end
        src_ready_d = (state_d == ST_FILL) && (pkt_len_d < MAX_LEN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            pkt_len_q   <= '0;
            rd_idx_q    <= '0;
            idle_cnt_q  <= '0;
            ta_q        <= 1'b0;
            seen_q      <= 1'b0;
            ep_sel_q    <= 1'b0;
            hs_q        <= HS_NONE;
            valid_q     <= 1'b0;
            toggle_q    <= 1'b0;
            src_ready_q <= 1'b0;
        end else if (usb_rst) begin
            state_q     <= ST_FILL;
            pkt_len_q   <= '0;
            rd_idx_q    <= '0;
            idle_cnt_q  <= '0;
            ta_q        <= 1'b0;
            seen_q      <= 1'b0;
            ep_sel_q    <= 1'b0;
            hs_q        <= HS_NONE;
            valid_q     <= 1'b0;
            toggle_q    <= 1'b0;
            src_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_len_q   <= pkt_len_d;
            rd_idx_q    <= rd_idx_d;
            idle_cnt_q  <= idle_cnt_d;
            ta_q        <= transaction_active;
            seen_q      <= seen_d;
            ep_sel_q    <= ep_sel_d;
            hs_q        <= hs_d;
            valid_q     <= valid_d;
            toggle_q    <= toggle_d;
            src_ready_q <= src_ready_d;
        end
    end

    usb_pkt_buf #(
        .DEPTH (MAX_PKT),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .rst_ni    (rst),
        .clr_i     (usb_rst),
        .wr_en_i   (buf_wr_en),
        .wr_addr_i (pkt_len_q[AW-1:0]),
        .wr_data_i (src_data),
        .rd_en_i   (buf_rd_en),
        .rd_addr_i (buf_rd_addr),
        .rd_data_o (buf_rd_data)
    );

    assign data_in       = buf_rd_data;
    assign data_in_valid = valid_q;
    assign data_toggle   = toggle_q;
    assign handshake     = hs_q;
    assign ep_sel        = ep_sel_q;
    assign src_ready     = src_ready_q;

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Directed self-checking bench for usb_in_packetizer (EP1, 64-byte packets,
// shortened idle timeout).
module tb_usb_in_packetizer;

    logic       clk, rst, usb_rst;
    logic       transaction_active, direction_in, setup, success, data_strobe;
    logic [3:0] endpoint;
    logic [7:0] data_in, src_data;
    logic       data_in_valid, data_toggle, ep_sel, src_valid, src_ready;
    logic       flush, stall, clear_toggle;
    logic [1:0] handshake;

    int n_cmp = 0;
    int n_err = 0;

    usb_in_packetizer #(
        .EP_NUM       (1),
        .MAX_PKT      (64),
        .IDLE_TIMEOUT (40)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .usb_rst            (usb_rst),
        .transaction_active (transaction_active),
        .endpoint           (endpoint),
        .direction_in       (direction_in),
        .setup              (setup),
        .success            (success),
        .data_strobe        (data_strobe),
        .data_in            (data_in),
        .data_in_valid      (data_in_valid),
        .data_toggle        (data_toggle),
        .handshake          (handshake),
        .ep_sel             (ep_sel),
        .src_data           (src_data),
        .src_valid          (src_valid),
        .src_ready          (src_ready),
        .flush              (flush),
        .stall              (stall),
        .clear_toggle       (clear_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [7:0] base, input bit flush_last, input string name);
        for (int i = 0; i < n; i++) begin
            int w;
            src_data  = base + 8'(i);
            src_valid = 1'b1;
            flush     = flush_last && (i == n - 1);
            w = 0;
            while (src_ready !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            if (w == 50) begin
                n_cmp++; n_err++;
                $display("FAIL %s src_ready_wait byte %0d: got src_ready=%b, required 1 within 50 cycles", name, i, src_ready);
            end
            tick();
        end
        src_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic in_txn(input logic [3:0] ep, input logic [1:0] exp_hs, input int nbytes,
                          input logic [7:0] base, input bit ack, input string name);
        logic exp_sel;
        exp_sel = (ep == 4'd1);
        endpoint = ep; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
        tick();
        n_cmp++; if (ep_sel !== exp_sel) begin n_err++; $display("FAIL %s ep_sel_start: got %b required %b", name, ep_sel, exp_sel); end
        n_cmp++; if (handshake !== exp_hs) begin n_err++; $display("FAIL %s handshake: got %b required %b", name, handshake, exp_hs); end
        for (int i = 0; i < nbytes; i++) begin
            n_cmp++; if (data_in_valid !== 1'b1) begin n_err++; $display("FAIL %s valid byte %0d: got %b required 1", name, i, data_in_valid); end
            n_cmp++; if (data_in !== base + 8'(i)) begin n_err++; $display("FAIL %s data byte %0d: got %h required %h", name, i, data_in, base + 8'(i)); end
            data_strobe = 1'b1;
            tick();
            data_strobe = 1'b0;
            repeat (7) tick();
        end
        n_cmp++; if (data_in_valid !== 1'b0) begin n_err++; $display("FAIL %s valid_after_last: got %b required 0", name, data_in_valid); end
        if (ack) begin
            success = 1'b1;
            tick();
            success = 1'b0;
        end
        tick();
        transaction_active = 1'b0;
        tick();
        n_cmp++; if (ep_sel !== 1'b0) begin n_err++; $display("FAIL %s ep_sel_end: got %b required 0", name, ep_sel); end
        n_cmp++; if (handshake !== 2'b01) begin n_err++; $display("FAIL %s handshake_end: got %b required 01", name, handshake); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++; if (data_in !== 8'h00) begin n_err++; $display("FAIL reset data_in: got %h required 00", data_in); end
        n_cmp++; if (data_in_valid !== 1'b0) begin n_err++; $display("FAIL reset valid: got %b required 0", data_in_valid); end
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL reset toggle: got %b required 0", data_toggle); end
        n_cmp++; if (handshake !== 2'b01) begin n_err++; $display("FAIL reset handshake: got %b required 01", handshake); end
        n_cmp++; if (ep_sel !== 1'b0) begin n_err++; $display("FAIL reset ep_sel: got %b required 0", ep_sel); end
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL reset src_ready: got %b required 0", src_ready); end
        rst = 1'b1;
        tick();
        n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL post_reset src_ready: got %b required 1", src_ready); end
    endtask

    task automatic test_full_packet();
        push(64, 8'h00, 1'b0, "full_push");
        tick();
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL full armed src_ready: got %b required 0", src_ready); end
        in_txn(4'd1, 2'b00, 64, 8'h00, 1'b1, "full_in");
        n_cmp++; if (data_toggle !== 1'b1) begin n_err++; $display("FAIL full toggle: got %b required 1", data_toggle); end
        n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL full refill src_ready: got %b required 1", src_ready); end
    endtask

    task automatic test_idle_timeout();
        push(5, 8'hA0, 1'b0, "idle_push");
        repeat (10) tick();
        in_txn(4'd1, 2'b10, 0, 8'h00, 1'b0, "idle_early_nak");
        n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL idle still_filling src_ready: got %b required 1", src_ready); end
        repeat (60) tick();
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL idle armed src_ready: got %b required 0", src_ready); end
        in_txn(4'd1, 2'b00, 5, 8'hA0, 1'b1, "idle_in");
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL idle toggle: got %b required 0", data_toggle); end
    endtask

    task automatic test_replay();
        push(64, 8'h40, 1'b0, "replay_push");
        in_txn(4'd1, 2'b00, 64, 8'h40, 1'b0, "replay_first");
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL replay toggle_kept: got %b required 0", data_toggle); end
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL replay still_armed src_ready: got %b required 0", src_ready); end
        in_txn(4'd1, 2'b00, 64, 8'h40, 1'b1, "replay_second");
        n_cmp++; if (data_toggle !== 1'b1) begin n_err++; $display("FAIL replay toggle_flip: got %b required 1", data_toggle); end
    endtask

    task automatic test_zlp();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL zlp armed src_ready: got %b required 0", src_ready); end
        in_txn(4'd1, 2'b00, 0, 8'h00, 1'b1, "zlp_in");
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL zlp toggle: got %b required 0", data_toggle); end
    endtask

    task automatic test_stall_and_other_ep();
        push(3, 8'h10, 1'b1, "stall_push");
        stall = 1'b1;
        in_txn(4'd1, 2'b11, 0, 8'h00, 1'b0, "stall_in");
        in_txn(4'd2, 2'b01, 0, 8'h00, 1'b0, "other_ep_in");
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL stall toggle_kept: got %b required 0", data_toggle); end
        stall = 1'b0;
        in_txn(4'd1, 2'b00, 3, 8'h10, 1'b1, "unstall_in");
        n_cmp++; if (data_toggle !== 1'b1) begin n_err++; $display("FAIL unstall toggle: got %b required 1", data_toggle); end
        clear_toggle = 1'b1;
        tick();
        clear_toggle = 1'b0;
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL clear_toggle: got %b required 0", data_toggle); end
    endtask

    task automatic test_reset_mid_send();
        push(8, 8'h20, 1'b1, "rst_pre_push");
        in_txn(4'd1, 2'b00, 8, 8'h20, 1'b1, "rst_pre_in");
        push(64, 8'h80, 1'b0, "rst_push");
        endpoint = 4'd1; direction_in = 1'b1; setup = 1'b0; transaction_active = 1'b1;
        tick();
        n_cmp++; if (handshake !== 2'b00) begin n_err++; $display("FAIL rst_send handshake: got %b required 00", handshake); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (data_in !== 8'h80 + 8'(i)) begin n_err++; $display("FAIL rst_send data byte %0d: got %h required %h", i, data_in, 8'h80 + 8'(i)); end
            data_strobe = 1'b1;
            tick();
            data_strobe = 1'b0;
            repeat (7) tick();
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (data_in !== 8'h00) begin n_err++; $display("FAIL midrst data_in: got %h required 00", data_in); end
        n_cmp++; if (data_in_valid !== 1'b0) begin n_err++; $display("FAIL midrst valid: got %b required 0", data_in_valid); end
        n_cmp++; if (data_toggle !== 1'b0) begin n_err++; $display("FAIL midrst toggle: got %b required 0", data_toggle); end
        n_cmp++; if (handshake !== 2'b01) begin n_err++; $display("FAIL midrst handshake: got %b required 01", handshake); end
        n_cmp++; if (ep_sel !== 1'b0) begin n_err++; $display("FAIL midrst ep_sel: got %b required 0", ep_sel); end
        transaction_active = 1'b0;
        tick();
        rst = 1'b1;
        repeat (2) tick();
        in_txn(4'd1, 2'b10, 0, 8'h00, 1'b0, "post_rst_nak");
        push(4, 8'h30, 1'b1, "usbrst_push");
        usb_rst = 1'b1;
        tick();
        n_cmp++; if (src_ready !== 1'b0) begin n_err++; $display("FAIL usb_rst src_ready: got %b required 0", src_ready); end
        usb_rst = 1'b0;
        tick();
        n_cmp++; if (src_ready !== 1'b1) begin n_err++; $display("FAIL usb_rst release src_ready: got %b required 1", src_ready); end
        in_txn(4'd1, 2'b10, 0, 8'h00, 1'b0, "post_usbrst_nak");
    endtask

    initial begin
        rst = 1'b0; usb_rst = 1'b0; transaction_active = 1'b0; endpoint = 4'd0;
        direction_in = 1'b0; setup = 1'b0; success = 1'b0; data_strobe = 1'b0;
        src_data = 8'h00; src_valid = 1'b0; flush = 1'b0; stall = 1'b0; clear_toggle = 1'b0;
        test_reset();
        test_full_packet();
        test_idle_timeout();
        test_replay();
        test_zlp();
        test_stall_and_other_ep();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
